// File: rtl/mouse_player_arbiter_pkg.sv
// Shared constants and state encoding for the mouse arbiter and its neighbours
// (player limiters, ball logic).
package mouse_player_arbiter_pkg;

    localparam int unsigned XW    = 12;  // x coordinate width
    localparam int unsigned CNT_W = 7;   // tick counter width, holds up to AIR_TICKS

    localparam logic [XW-1:0] NET_X    = 12'd480;  // ball_x >= NET_X means right half
    localparam logic [XW-1:0] P0_RST_X = 12'd215;
    localparam logic [XW-1:0] P1_RST_X = 12'd737;

    localparam int unsigned HYST_TICKS = 8;   // ticks on the far side before a swap request
    localparam int unsigned AIR_TICKS  = 60;  // ticks the owner counts as airborne after a click

    typedef enum logic [1:0] {
        OWN    = 2'd0,
        HOLD   = 2'd1,
        SWITCH = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mouse_player_arbiter_tick_counter.sv
// Saturating tick counter: synchronous clear beats load, load beats count.
// Counts up towards MAX or down towards 0, never wrapping.
module arb_tick_counter #(
    parameter int unsigned W   = 7,
    parameter int unsigned MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    // next count: clear, load, then saturating step
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (inc_i && cnt_q < MAX_V)
            cnt_d = cnt_q + 1'b1;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mouse_player_arbiter.sv
// Mouse arbiter: hands the single mouse to the player whose half holds the
// ball, with hysteresis, and never swaps while the owner is mid-jump.
// Optional macro SWAP_BTN_EN adds a swap_btn input (right button) whose
// rising edge forces a one-clock swap request.
module mouse_player_arbiter
    import mouse_player_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [XW-1:0] xpos,
    input  logic          click_mouse,
`ifdef SWAP_BTN_EN
    input  logic          swap_btn,
`endif
    input  logic [XW-1:0] ball_x,
    input  logic          point_end,
    output logic [XW-1:0] xpos_p0,
    output logic          click_p0,
    output logic [XW-1:0] xpos_p1,
    output logic          click_p1,
    output logic          owner
);

    localparam logic [CNT_W-1:0] HYST_V = CNT_W'(HYST_TICKS);
    localparam logic [CNT_W-1:0] AIR_V  = CNT_W'(AIR_TICKS);

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic [XW-1:0] xp0_q, xp0_d, xp1_q, xp1_d;
    logic          ck0_q, ck0_d, ck1_q, ck1_d;
    logic          blk_q, blk_d;       // button held across a swap; blocked until released
    logic          click_prev_q;
    logic [CNT_W-1:0] hyst_cnt, air_cnt;

    logic far, in_switch, airborne, swap_req, btn_rise, click_fwd, air_load;

`ifdef SWAP_BTN_EN
    logic btn_prev_q;
    // remember the right button for edge detection
    always_ff @(posedge clk) begin
        if (rst) btn_prev_q <= 1'b0;
        else     btn_prev_q <= swap_btn;
    end
    assign btn_rise = swap_btn & ~btn_prev_q;
`else
    assign btn_rise = 1'b0;
`endif

    assign far       = (ball_x >= NET_X) != owner_q;
    assign in_switch = (state_q == SWITCH);
    assign airborne  = (air_cnt != '0);
    assign swap_req  = (hyst_cnt == HYST_V) | btn_rise;
    assign click_fwd = click_mouse & ~blk_q & ~in_switch;
    // only a fresh press in OWN starts a jump; presses during HOLD do not extend it
    assign air_load  = (state_q == OWN) & click_mouse & ~click_prev_q & ~blk_q;

    arb_tick_counter #(.W(CNT_W), .MAX(HYST_TICKS)) u_hyst (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (point_end | in_switch | (tick & ~far)),
        .load_i    (1'b0),
        .load_val_i('0),
        .inc_i     (tick & far),
        .dec_i     (1'b0),
        .cnt_o     (hyst_cnt)
    );

    arb_tick_counter #(.W(CNT_W), .MAX(AIR_TICKS)) u_air (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (point_end | in_switch),
        .load_i    (air_load),
        .load_val_i(AIR_V),
        .inc_i     (1'b0),
        .dec_i     (tick),
        .cnt_o     (air_cnt)
    );

    // next state, ownership and routed outputs
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        xp0_d   = xp0_q;
        xp1_d   = xp1_q;
        ck0_d   = 1'b0;
        ck1_d   = 1'b0;
        blk_d   = blk_q & click_mouse;
        unique case (state_q)
            OWN: begin
                if (swap_req && !point_end)
                    state_d = airborne ? HOLD : SWITCH;
            end
            HOLD: begin
                if (point_end || (tick && !far))
                    state_d = OWN;
                else if (!airborne)
                    state_d = SWITCH;
            end
            SWITCH: begin
                state_d = OWN;
                owner_d = ~owner_q;
                blk_d   = click_mouse;
            end
            default: state_d = OWN;
        endcase
        if (!in_switch) begin
            if (owner_q) begin
                xp1_d = xpos;
                ck1_d = click_fwd;
            end else begin
                xp0_d = xpos;
                ck0_d = click_fwd;
            end
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= OWN;
            owner_q      <= 1'b0;
            xp0_q        <= P0_RST_X;
            xp1_q        <= P1_RST_X;
            ck0_q        <= 1'b0;
            ck1_q        <= 1'b0;
            blk_q        <= 1'b0;
            click_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            xp0_q        <= xp0_d;
            xp1_q        <= xp1_d;
            ck0_q        <= ck0_d;
            ck1_q        <= ck1_d;
            blk_q        <= blk_d;
            click_prev_q <= click_mouse;
        end
    end

    assign xpos_p0  = xp0_q;
    assign click_p0 = ck0_q;
    assign xpos_p1  = xp1_q;
    assign click_p1 = ck1_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_mouse_player_arbiter.sv
// Self-checking bench for mouse_player_arbiter: expected output snapshots are
// queued as stimulus is driven and compared after the clock that produces them.
module tb_mouse_player_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [11:0] xpos = 12'd300;
    logic        click_mouse = 1'b0;
    logic [11:0] ball_x = 12'd100;
    logic        point_end = 1'b0;
    logic [11:0] xpos_p0, xpos_p1;
    logic        click_p0, click_p1, owner;
`ifdef SWAP_BTN_EN
    logic        swap_btn = 1'b0;
`endif

    mouse_player_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .xpos       (xpos),
        .click_mouse(click_mouse),
`ifdef SWAP_BTN_EN
        .swap_btn   (swap_btn),
`endif
        .ball_x     (ball_x),
        .point_end  (point_end),
        .xpos_p0    (xpos_p0),
        .click_p0   (click_p0),
        .xpos_p1    (xpos_p1),
        .click_p1   (click_p1),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] x0;
        logic        c0;
        logic [11:0] x1;
        logic        c1;
        logic        own;
    } out_t;

    out_t exp_q[$];
    int   nchk  = 0;
    int   npass = 0;

    function automatic out_t obs();
        return '{xpos_p0, click_p0, xpos_p1, click_p1, owner};
    endfunction

    // one clock with optional tick / point_end strobes; inputs change 1 after the edge
    task automatic clk1(input logic t, input logic pe);
        tick = t;
        point_end = pe;
        @(posedge clk);
        #1;
        tick = 1'b0;
        point_end = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; xpos = 12'd300; click_mouse = 1'b0; ball_x = 12'd100;
        clk1(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_t e;
        rst = 1'b1; xpos = 12'd300; click_mouse = 1'b0; ball_x = 12'd100;
        exp_q.push_back('{12'd215, 1'b0, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL reset_state got %h exp %h", obs(), e); else npass++;
        rst = 1'b0;
        exp_q.push_back('{12'd300, 1'b0, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL reset_first_route got %h exp %h", obs(), e); else npass++;
    endtask

    task automatic test_switch();
        out_t e;
        do_reset();
        ball_x = 12'd600;
        for (int i = 0; i < 8; i++) clk1(1'b1, 1'b0);
        exp_q.push_back('{12'd300, 1'b0, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);  // request seen, SWITCH entered
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL switch_pre got %h exp %h", obs(), e); else npass++;
        xpos = 12'd700;
        exp_q.push_back('{12'd300, 1'b0, 12'd737, 1'b0, 1'b1});
        clk1(1'b0, 1'b0);  // SWITCH: everything held, owner toggles
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL switch_toggle got %h exp %h", obs(), e); else npass++;
        exp_q.push_back('{12'd300, 1'b0, 12'd700, 1'b0, 1'b1});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL switch_route_p1 got %h exp %h", obs(), e); else npass++;
    endtask

    task automatic test_hold();
        out_t e;
        do_reset();
        click_mouse = 1'b1;
        exp_q.push_back('{12'd300, 1'b1, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);  // jump starts: 60 ticks airborne
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL hold_click_fwd got %h exp %h", obs(), e); else npass++;
        click_mouse = 1'b0;
        clk1(1'b1, 1'b0);
        ball_x = 12'd600;
        for (int i = 0; i < 8; i++) clk1(1'b1, 1'b0);   // 9 ticks so far
        clk1(1'b0, 1'b0);                               // HOLD
        for (int i = 0; i < 20; i++) clk1(1'b1, 1'b0);  // 29 ticks
        click_mouse = 1'b1;
        exp_q.push_back('{12'd300, 1'b1, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);  // forwarded in HOLD, must not extend the jump
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL hold_click_in_hold got %h exp %h", obs(), e); else npass++;
        click_mouse = 1'b0;
        for (int i = 0; i < 31; i++) clk1(1'b1, 1'b0);  // 60 ticks: air reaches 0
        exp_q.push_back('{12'd300, 1'b0, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);  // HOLD -> SWITCH, still owner 0
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL hold_still_owner0 got %h exp %h", obs(), e); else npass++;
        exp_q.push_back('{12'd300, 1'b0, 12'd737, 1'b0, 1'b1});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL hold_then_switch got %h exp %h", obs(), e); else npass++;
    endtask

    task automatic test_ball_return();
        out_t e;
        do_reset();
        ball_x = 12'd600;
        for (int i = 0; i < 5; i++) clk1(1'b1, 1'b0);
        ball_x = 12'd400;
        clk1(1'b1, 1'b0);
        ball_x = 12'd600;
        for (int i = 0; i < 7; i++) clk1(1'b1, 1'b0);
        clk1(1'b0, 1'b0);
        exp_q.push_back('{12'd300, 1'b0, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL return_hyst_clear got %h exp %h", obs(), e); else npass++;
        // ball comes back while owner is airborne
        do_reset();
        click_mouse = 1'b1;
        clk1(1'b0, 1'b0);
        click_mouse = 1'b0;
        ball_x = 12'd600;
        for (int i = 0; i < 8; i++) clk1(1'b1, 1'b0);
        clk1(1'b0, 1'b0);  // HOLD
        ball_x = 12'd400;
        for (int i = 0; i < 60; i++) clk1(1'b1, 1'b0);
        clk1(1'b0, 1'b0);
        exp_q.push_back('{12'd300, 1'b0, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL return_from_hold got %h exp %h", obs(), e); else npass++;
    endtask

    task automatic test_held_click();
        out_t e;
        do_reset();
        click_mouse = 1'b1;
        clk1(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) clk1(1'b1, 1'b0);  // jump expires
        ball_x = 12'd600;
        for (int i = 0; i < 8; i++) clk1(1'b1, 1'b0);
        exp_q.push_back('{12'd300, 1'b1, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL held_pre_switch got %h exp %h", obs(), e); else npass++;
        exp_q.push_back('{12'd300, 1'b0, 12'd737, 1'b0, 1'b1});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL held_in_switch got %h exp %h", obs(), e); else npass++;
        exp_q.push_back('{12'd300, 1'b0, 12'd300, 1'b0, 1'b1});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL held_blocked got %h exp %h", obs(), e); else npass++;
        click_mouse = 1'b0;
        clk1(1'b0, 1'b0);
        click_mouse = 1'b1;
        exp_q.push_back('{12'd300, 1'b0, 12'd300, 1'b1, 1'b1});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL held_repress got %h exp %h", obs(), e); else npass++;
        click_mouse = 1'b0;
    endtask

    task automatic test_point_end();
        out_t e;
        do_reset();
        ball_x = 12'd600;
        for (int i = 0; i < 7; i++) clk1(1'b1, 1'b0);
        exp_q.push_back('{12'd300, 1'b0, 12'd737, 1'b0, 1'b0});
        clk1(1'b1, 1'b1);  // point_end beats the tick
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL pe_same_clk got %h exp %h", obs(), e); else npass++;
        for (int i = 0; i < 7; i++) clk1(1'b1, 1'b0);
        clk1(1'b0, 1'b0);
        exp_q.push_back('{12'd300, 1'b0, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL pe_no_swap got %h exp %h", obs(), e); else npass++;
        clk1(1'b1, 1'b0);  // eighth tick since the clear
        clk1(1'b0, 1'b0);  // SWITCH entered
        rst = 1'b1; xpos = 12'd500;
        exp_q.push_back('{12'd215, 1'b0, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL rst_in_switch got %h exp %h", obs(), e); else npass++;
        rst = 1'b0;
        exp_q.push_back('{12'd500, 1'b0, 12'd737, 1'b0, 1'b0});
        clk1(1'b0, 1'b0);
        e = exp_q.pop_front(); nchk++;
        if (obs() !== e) $display("FAIL rst_no_residue got %h exp %h", obs(), e); else npass++;
    endtask

    initial begin
        test_reset();
        test_switch();
        test_hold();
        test_ball_return();
        test_held_click();
        test_point_end();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
